bp_fe_npc_gen: RTL and testbench

- Parametrised next-PC generator for the front end: N-deep fetch PC pipeline (stages_p), resume/stall FSM and return-address stack (RAS).
- Sits between the FE command decoder and the I$/ITLB fetch port.
- Produces fetch PCs and resolves redirects, late overrides (taken/ret) and fetch failures.
- The consumer (instr scan + FE queue) reports on the last stage each cycle.

---
 rtl/bp_fe_npc_gen.sv | 215 +++++++++++++++++++++
 tb/tb_bp_fe_npc_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_npc_gen.sv
// bp_fe_npc_gen: next-PC generator for the fetch front end.
//
// Holds a stages_p-deep fetch PC pipeline. It also runs a wait/stall/run
// resume FSM and, optionally, a return-address stack. Each cycle it picks the
// next fetch PC from, in priority order:
//   1. a backend redirect,
//   2. the resume PC,
//   3. a late ret/taken override from the last-stage scan,
//   4. a BTB hit,
//   5. the sequential increment.
//
// Optional feature macro: BP_FE_NPC_RAS_EN
//   defined   -> return-address stack is built; committed calls push and
//                committed returns pop and override.
//   undefined -> no RAS; ras_empty_o is tied 1 and returns never override.
//
// Ports:
//   clk_i, reset_n_i               clock, synchronous active-low reset
//   redirect_v_i / redirect_pc_i   non-speculative redirect (always accepted)
//   btb_v_i / btb_tgt_i            BTB hit for the current stage-0 lookup
//   ovr_taken_i / ovr_tgt_i        last-stage taken override
//   scan_call_i / scan_ret_i       last-stage call / return flags
//   commit_i                       consumer accepted the last-stage instr
//   ready_i                        downstream can take a fetch
//   fetch_v_o / fetch_pc_o         fetch request (fetch_pc_o is combinational)
//   fetch_yumi_i                   fetch accepted
//   last_v_o / last_pc_o           last pipeline stage
//   poison_o                       an in-flight fetch was killed this cycle
//   ras_empty_o                    RAS holds no entries
module bp_fe_npc_gen #(
  parameter int vaddr_width_p = 39,
  parameter int stages_p      = 2,
  parameter int ras_depth_p   = 8,
  parameter int instr_bytes_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  input  logic                     btb_v_i,
  input  logic [vaddr_width_p-1:0] btb_tgt_i,
  input  logic                     ovr_taken_i,
  input  logic [vaddr_width_p-1:0] ovr_tgt_i,
  input  logic                     scan_call_i,
  input  logic                     scan_ret_i,
  input  logic                     commit_i,
  input  logic                     ready_i,
  output logic                     fetch_v_o,
  output logic [vaddr_width_p-1:0] fetch_pc_o,
  input  logic                     fetch_yumi_i,
  output logic                     last_v_o,
  output logic [vaddr_width_p-1:0] last_pc_o,
  output logic                     poison_o,
  output logic                     ras_empty_o
);

  localparam logic [1:0] e_wait  = 2'd0;
  localparam logic [1:0] e_stall = 2'd1;
  localparam logic [1:0] e_run   = 2'd2;

  localparam logic [vaddr_width_p-1:0] instr_inc = vaddr_width_p'(instr_bytes_p);

  logic [1:0]               state, state_n;
  logic [stages_p-1:0]      stage_v;
  logic [vaddr_width_p-1:0] stage_pc [stages_p];
  logic [vaddr_width_p-1:0] resume_pc, resume_n;
  logic [vaddr_width_p-1:0] npc;
  logic [vaddr_width_p-1:0] ras_top;
  logic                     fail, ret_ovr, tkn_ovr, kill, young_v;

  // Outputs are forced quiet while reset is asserted so nothing leaks out of
  // the cycle that drops the in-flight stages.
  assign last_v_o  = reset_n_i & stage_v[stages_p-1];
  assign last_pc_o = reset_n_i ? stage_pc[stages_p-1] : '0;

  assign young_v = |stage_v[stages_p-2:0];
  assign fail    = last_v_o & ~commit_i;
  assign tkn_ovr = last_v_o & commit_i & ovr_taken_i & ~ret_ovr;
  assign kill    = redirect_v_i | fail | ret_ovr | tkn_ovr;

  assign poison_o   = reset_n_i & kill & young_v;
  assign fetch_v_o  = reset_n_i & (redirect_v_i | ((state != e_wait) & ready_i & ~fail));
  assign fetch_pc_o = reset_n_i ? npc : '0;

  // Next fetch PC selection, highest priority first.
  always_comb begin
    if (redirect_v_i) begin
      npc = redirect_pc_i;
    end else if ((state != e_run) || fail) begin
      npc = resume_pc;
    end else if (ret_ovr) begin
      npc = ras_top;
    end else if (tkn_ovr) begin
      npc = ovr_tgt_i;
    end else if (btb_v_i) begin
      npc = btb_tgt_i;
    end else begin
      npc = stage_pc[0] + instr_inc;
    end
  end

  // Resume PC: where fetch restarts after a stall or where it was steered.
  always_comb begin
    if (redirect_v_i) begin
      resume_n = redirect_pc_i;
    end else if (fail) begin
      resume_n = last_pc_o;
    end else if (ret_ovr || tkn_ovr) begin
      resume_n = npc;
    end else begin
      resume_n = resume_pc;
    end
  end

  // Resume FSM. A fetch accepted in the same cycle as a redirect already
  // carries the redirect target, so the FSM goes straight to run and the
  // sequential path continues from it instead of refetching.
  always_comb begin
    case (state)
      e_wait: begin
        if (redirect_v_i && fetch_yumi_i) begin
          state_n = e_run;
        end else if (redirect_v_i) begin
          state_n = e_stall;
        end else begin
          state_n = e_wait;
        end
      end
      e_stall: begin
        if (fetch_yumi_i && (redirect_v_i || !fail)) begin
          state_n = e_run;
        end else begin
          state_n = e_stall;
        end
      end
      e_run: begin
        if (redirect_v_i) begin
          state_n = e_run;
        end else if (fail) begin
          state_n = e_stall;
        end else begin
          state_n = e_run;
        end
      end
      default: state_n = e_wait;
    endcase
  end

  // FSM, resume PC and the fetch pipeline; the pipeline advances every cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state     <= e_wait;
      resume_pc <= '0;
      stage_v   <= '0;
      for (int i = 0; i < stages_p; i++) begin
        stage_pc[i] <= '0;
      end
    end else begin
      state       <= state_n;
      resume_pc   <= resume_n;
      stage_v[0]  <= fetch_yumi_i;
      stage_pc[0] <= npc;
      for (int i = 1; i < stages_p; i++) begin
        stage_v[i]  <= stage_v[i-1] & ~kill;
        stage_pc[i] <= stage_pc[i-1];
      end
    end
  end

`ifdef BP_FE_NPC_RAS_EN
  localparam int ptr_w = $clog2(ras_depth_p);

  logic [vaddr_width_p-1:0] ras_mem [ras_depth_p];
  logic [ptr_w-1:0]         ras_ptr, ras_top_idx;
  logic [ptr_w:0]           ras_cnt;
  logic                     ras_push, ras_pop;
  logic [vaddr_width_p-1:0] ras_push_val;

  assign ras_top_idx  = ras_ptr - ptr_w'(1);
  assign ras_top      = ras_mem[ras_top_idx];
  assign ras_empty_o  = ~reset_n_i | (ras_cnt == '0);
  assign ret_ovr      = last_v_o & commit_i & scan_ret_i & ~ras_empty_o;
  assign ras_push     = scan_call_i & last_v_o & commit_i;
  assign ras_pop      = ret_ovr;
  assign ras_push_val = last_pc_o + instr_inc;

  // Circular RAS: a push when full overwrites the oldest entry; a combined
  // call+ret replaces the top in place.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push && ras_pop) begin
      ras_mem[ras_top_idx] <= ras_push_val;
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= ras_push_val;
      ras_ptr          <= ras_ptr + ptr_w'(1);
      if (ras_cnt != (ptr_w + 1)'(ras_depth_p)) begin
        ras_cnt <= ras_cnt + (ptr_w + 1)'(1);
      end
    end else if (ras_pop) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - (ptr_w + 1)'(1);
    end
  end
`else
  logic [ras_depth_p:0] unused_ras;

  assign ras_top     = '0;
  assign ras_empty_o = 1'b1;
  assign ret_ovr     = 1'b0;
  assign unused_ras  = {{ras_depth_p{1'b0}}, scan_call_i ^ scan_ret_i};
`endif

endmodule

// File: tb/tb_bp_fe_npc_gen.sv
// Directed testbench for bp_fe_npc_gen (default parameters: 39-bit VA,
// 2 stages, 8-entry RAS, 4-byte instructions). RAS scenarios depend on
// BP_FE_NPC_RAS_EN; without it the bench checks that returns never override.
module tb_bp_fe_npc_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_v;
  logic [38:0] redirect_pc;
  logic        btb_v;
  logic [38:0] btb_tgt;
  logic        ovr_taken;
  logic [38:0] ovr_tgt;
  logic        scan_call, scan_ret, commit, ready, yumi_en;
  logic        fetch_v, fetch_yumi, last_v, poison, ras_empty;
  logic [38:0] fetch_pc, last_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign fetch_yumi = fetch_v & yumi_en;

  bp_fe_npc_gen dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .redirect_v_i (redirect_v),
    .redirect_pc_i(redirect_pc),
    .btb_v_i      (btb_v),
    .btb_tgt_i    (btb_tgt),
    .ovr_taken_i  (ovr_taken),
    .ovr_tgt_i    (ovr_tgt),
    .scan_call_i  (scan_call),
    .scan_ret_i   (scan_ret),
    .commit_i     (commit),
    .ready_i      (ready),
    .fetch_v_o    (fetch_v),
    .fetch_pc_o   (fetch_pc),
    .fetch_yumi_i (fetch_yumi),
    .last_v_o     (last_v),
    .last_pc_o    (last_pc),
    .poison_o     (poison),
    .ras_empty_o  (ras_empty)
  );

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_scan();
    btb_v = 1'b0; ovr_taken = 1'b0; scan_call = 1'b0; scan_ret = 1'b0;
    redirect_v = 1'b0; commit = 1'b1;
  endtask

  // Bounded wait until the last stage holds pc; an expired budget counts as a failure.
  task automatic wait_last(input logic [38:0] pc, input string name);
    int k;
    k = 0;
    while (!(last_v === 1'b1 && last_pc === pc) && k < 40) begin
      adv(); #1; k++;
    end
    total++;
    if (k >= 40) begin
      bad++; $display("FAIL %s: last_pc=%h never valid, want %h", name, last_pc, pc);
    end
  endtask

  task automatic test_reset();
    adv(); adv(); #1;
    total++; if (fetch_v !== 1'b0) begin bad++; $display("FAIL rst_fetch_v: got %b want 0", fetch_v); end
    total++; if (last_v !== 1'b0) begin bad++; $display("FAIL rst_last_v: got %b want 0", last_v); end
    total++; if (poison !== 1'b0) begin bad++; $display("FAIL rst_poison: got %b want 0", poison); end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL rst_ras_empty: got %b want 1", ras_empty); end
    total++; if (fetch_pc !== 39'h0) begin bad++; $display("FAIL rst_fetch_pc: got %h want 0", fetch_pc); end
    total++; if (last_pc !== 39'h0) begin bad++; $display("FAIL rst_last_pc: got %h want 0", last_pc); end
    reset_n = 1'b1;
    adv(); #1;
    total++; if (fetch_v !== 1'b0) begin bad++; $display("FAIL wait_fetch_v: got %b want 0", fetch_v); end
  endtask

  task automatic test_redirect_start();
    redirect_v = 1'b1; redirect_pc = 39'h8000_0000; #1;
    total++; if (fetch_v !== 1'b1) begin bad++; $display("FAIL start_fetch_v: got %b want 1", fetch_v); end
    total++; if (fetch_pc !== 39'h8000_0000) begin bad++; $display("FAIL start_pc0: got %h want 80000000", fetch_pc); end
    adv(); redirect_v = 1'b0; #1;
    total++; if (fetch_pc !== 39'h8000_0004) begin bad++; $display("FAIL start_pc1: got %h want 80000004", fetch_pc); end
    total++; if (last_v !== 1'b0) begin bad++; $display("FAIL start_last_v1: got %b want 0", last_v); end
    adv(); #1;
    total++; if (fetch_pc !== 39'h8000_0008) begin bad++; $display("FAIL start_pc2: got %h want 80000008", fetch_pc); end
    total++; if (last_v !== 1'b1 || last_pc !== 39'h8000_0000) begin
      bad++; $display("FAIL start_last2: got v=%b pc=%h want v=1 pc=80000000", last_v, last_pc);
    end
  endtask

  task automatic test_fail();
    redirect_v = 1'b1; redirect_pc = 39'h0F8;
    adv(); redirect_v = 1'b0; #1;
    wait_last(39'h100, "fail_reach");
    commit = 1'b0; #1;
    total++; if (poison !== 1'b1) begin bad++; $display("FAIL fail_poison: got %b want 1", poison); end
    total++; if (fetch_v !== 1'b0) begin bad++; $display("FAIL fail_fetch_v: got %b want 0", fetch_v); end
    adv(); commit = 1'b1; #1;
    total++; if (last_v !== 1'b0) begin bad++; $display("FAIL fail_last_v: got %b want 0", last_v); end
    total++; if (fetch_v !== 1'b1 || fetch_pc !== 39'h100) begin
      bad++; $display("FAIL fail_refetch: got v=%b pc=%h want v=1 pc=100", fetch_v, fetch_pc);
    end
    wait_last(39'h100, "fail_resume");
  endtask

  task automatic test_override();
    redirect_v = 1'b1; redirect_pc = 39'h1FC;
    adv(); redirect_v = 1'b0; #1;
    wait_last(39'h1FC, "ovr_reach");
    btb_v = 1'b1; btb_tgt = 39'h400; ovr_taken = 1'b1; ovr_tgt = 39'h800; #1;
    total++; if (fetch_pc !== 39'h800) begin bad++; $display("FAIL ovr_pc: got %h want 800", fetch_pc); end
    total++; if (poison !== 1'b1) begin bad++; $display("FAIL ovr_poison: got %b want 1", poison); end
    adv(); clear_scan(); #1;
    total++; if (last_v !== 1'b0) begin bad++; $display("FAIL ovr_killed: got %b want 0", last_v); end
    total++; if (fetch_pc !== 39'h804) begin bad++; $display("FAIL ovr_seq: got %h want 804", fetch_pc); end
    wait_last(39'h800, "btb_reach");
    btb_v = 1'b1; btb_tgt = 39'h400; #1;
    total++; if (fetch_pc !== 39'h400 || poison !== 1'b0) begin
      bad++; $display("FAIL btb_pc: got pc=%h poison=%b want pc=400 poison=0", fetch_pc, poison);
    end
    adv(); clear_scan(); #1;
    total++; if (fetch_pc !== 39'h404 || last_pc !== 39'h804 || last_v !== 1'b1) begin
      bad++; $display("FAIL btb_after: got pc=%h last=%h v=%b want 404/804/1", fetch_pc, last_pc, last_v);
    end
  endtask

`ifdef BP_FE_NPC_RAS_EN
  task automatic test_ras_overflow();
    logic [38:0] tgt;
    total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL ras_init_empty: got %b want 1", ras_empty); end
    redirect_v = 1'b1; redirect_pc = 39'h10;
    adv(); redirect_v = 1'b0; #1;
    for (int i = 1; i <= 9; i++) begin
      wait_last(39'(i * 16), "call_reach");
      scan_call = 1'b1; ovr_taken = 1'b1; ovr_tgt = 39'((i + 1) * 16); #1;
      total++; if (fetch_pc !== 39'((i + 1) * 16)) begin
        bad++; $display("FAIL call_jump: got %h want %h", fetch_pc, 39'((i + 1) * 16));
      end
      adv(); clear_scan(); #1;
    end
    total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL ras_full_empty: got %b want 0", ras_empty); end
    tgt = 39'hA0;
    for (int j = 0; j < 8; j++) begin
      wait_last(tgt, "ret_reach");
      scan_ret = 1'b1; #1;
      tgt = 39'h94 - 39'(j * 16);
      total++; if (fetch_pc !== tgt || poison !== 1'b1) begin
        bad++; $display("FAIL ret_tgt: got pc=%h poison=%b want pc=%h poison=1", fetch_pc, poison, tgt);
      end
      adv(); clear_scan(); #1;
    end
    wait_last(39'h24, "ret9_reach");
    scan_ret = 1'b1; #1;
    total++; if (fetch_pc !== 39'h2C || poison !== 1'b0 || ras_empty !== 1'b1) begin
      bad++; $display("FAIL ret9: got pc=%h poison=%b empty=%b want 2c/0/1", fetch_pc, poison, ras_empty);
    end
    adv(); clear_scan(); #1;
  endtask

  task automatic test_call_ret();
    redirect_v = 1'b1; redirect_pc = 39'h10;
    adv(); redirect_v = 1'b0; #1;
    wait_last(39'h10, "cr_call_reach");
    scan_call = 1'b1; ovr_taken = 1'b1; ovr_tgt = 39'h50;
    adv(); clear_scan(); #1;
    wait_last(39'h50, "cr_reach");
    scan_call = 1'b1; scan_ret = 1'b1; #1;
    total++; if (fetch_pc !== 39'h14) begin bad++; $display("FAIL cr_pc: got %h want 14", fetch_pc); end
    adv(); clear_scan(); #1;
    total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL cr_count: empty=%b want 0", ras_empty); end
    wait_last(39'h14, "cr_ret_reach");
    scan_ret = 1'b1; #1;
    total++; if (fetch_pc !== 39'h54) begin bad++; $display("FAIL cr_newtop: got %h want 54", fetch_pc); end
    adv(); clear_scan(); #1;
    total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL cr_drain: empty=%b want 1", ras_empty); end
  endtask
`else
  task automatic test_no_ras();
    redirect_v = 1'b1; redirect_pc = 39'h10;
    adv(); redirect_v = 1'b0; #1;
    wait_last(39'h10, "noras_reach");
    scan_call = 1'b1; scan_ret = 1'b1; #1;
    total++; if (fetch_pc !== 39'h18 || poison !== 1'b0 || ras_empty !== 1'b1) begin
      bad++; $display("FAIL noras_ret: got pc=%h poison=%b empty=%b want 18/0/1", fetch_pc, poison, ras_empty);
    end
    adv(); clear_scan(); #1;
    wait_last(39'h14, "noras_ovr_reach");
    scan_ret = 1'b1; ovr_taken = 1'b1; ovr_tgt = 39'h70; #1;
    total++; if (fetch_pc !== 39'h70) begin bad++; $display("FAIL noras_ovr: got %h want 70", fetch_pc); end
    adv(); clear_scan(); #1;
  endtask
`endif

  task automatic test_reset_mid();
    redirect_v = 1'b1; redirect_pc = 39'h300;
    adv(); redirect_v = 1'b0; #1;
    wait_last(39'h300, "mid_reach");
    scan_call = 1'b1;
    adv(); clear_scan(); #1;
`ifdef BP_FE_NPC_RAS_EN
    total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL mid_pushed: empty=%b want 0", ras_empty); end
`endif
    reset_n = 1'b0; redirect_v = 1'b1; redirect_pc = 39'h900; #1;
    total++; if (poison !== 1'b0 || fetch_v !== 1'b0) begin
      bad++; $display("FAIL mid_in_rst: poison=%b fetch_v=%b want 0/0", poison, fetch_v);
    end
    adv(); reset_n = 1'b1; redirect_v = 1'b0; #1;
    total++; if (last_v !== 1'b0 || fetch_v !== 1'b0 || poison !== 1'b0 || ras_empty !== 1'b1) begin
      bad++; $display("FAIL mid_after: last_v=%b fetch_v=%b poison=%b empty=%b want 0/0/0/1",
                      last_v, fetch_v, poison, ras_empty);
    end
    adv(); #1;
    total++; if (fetch_v !== 1'b0 || last_v !== 1'b0) begin
      bad++; $display("FAIL mid_wait: fetch_v=%b last_v=%b want 0/0", fetch_v, last_v);
    end
    redirect_v = 1'b1; redirect_pc = 39'h500; #1;
    total++; if (fetch_v !== 1'b1 || fetch_pc !== 39'h500) begin
      bad++; $display("FAIL mid_restart: v=%b pc=%h want 1/500", fetch_v, fetch_pc);
    end
    adv(); redirect_v = 1'b0; #1;
    total++; if (fetch_pc !== 39'h504) begin bad++; $display("FAIL mid_seq: got %h want 504", fetch_pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; redirect_pc = '0; btb_tgt = '0; ovr_tgt = '0;
    ready = 1'b1; yumi_en = 1'b1;
    clear_scan();
    test_reset();
    test_redirect_start();
    test_fail();
    test_override();
`ifdef BP_FE_NPC_RAS_EN
    test_ras_overflow();
    test_call_ret();
`else
    test_no_ras();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
